// File: rtl/xbar_slave_mux_if.sv
// Bus bundle for the crossbar slave-side mux: master request side plus the single slave port.
// Modport master is the mux itself, which masters the slave port; slave is the surrounding environment.
interface xbar_slave_mux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        m_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic              m0_we;
  logic              m1_we;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic [1:0]        grnt;
  logic [1:0]        m_ack;
  logic [1:0]        m_err;
  logic [DATA_W-1:0] m_rdata;
  logic              s_req;
  logic [ADDR_W-1:0] s_addr;
  logic              s_we;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    input  m_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, grnt,
    input  s_ack, s_rdata,
    output m_ack, m_err, m_rdata, s_req, s_addr, s_we, s_wdata
  );

  modport slave (
    output m_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, grnt,
    output s_ack, s_rdata,
    input  m_ack, m_err, m_rdata, s_req, s_addr, s_we, s_wdata
  );
endinterface

// File: rtl/xbar_slave_mux.sv
// Slave-side routing stage of the 2-master crossbar: latches the granted request, runs the slave
// handshake and returns ack/rdata to the owner. Optional BUSY watchdog under XBAR_TIMEOUT_EN.
module xbar_slave_mux #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              resetn,
  xbar_slave_mux_if.master bus
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("xbar_slave_mux: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        m_ack_q, m_ack_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic              s_req_q, s_req_d;
  logic              s_we_q, s_we_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic              gnt_valid;
  logic              gnt_idx;
  logic [1:0]        owner_mask;

`ifdef XBAR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        m_err_q, m_err_d;
`endif

  assign owner_mask = owner_q ? 2'b10 : 2'b01;

  // 2'b11 is illegal from the arbiter and is treated like no grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (bus.grnt == 2'b01 && bus.m_req[0]) begin
      gnt_valid = 1'b1;
    end else if (bus.grnt == 2'b10 && bus.m_req[1]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_ack_d   = '0;
    m_rdata_d = m_rdata_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
`ifdef XBAR_TIMEOUT_EN
    cnt_d     = cnt_q;
    m_err_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d   = gnt_idx;
          s_addr_d  = gnt_idx ? bus.m1_addr  : bus.m0_addr;
          s_we_d    = gnt_idx ? bus.m1_we    : bus.m0_we;
          s_wdata_d = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
          s_req_d   = 1'b1;
          state_d   = BUSY;
`ifdef XBAR_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        // An ack on the watchdog's final cycle still completes normally.
        if (bus.s_ack) begin
          s_req_d   = 1'b0;
          m_rdata_d = bus.s_rdata;
          m_ack_d   = owner_mask;
          state_d   = DONE;
        end
`ifdef XBAR_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          s_req_d   = 1'b0;
          m_rdata_d = '0;
          m_ack_d   = owner_mask;
          m_err_d   = owner_mask;
          state_d   = DONE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      m_ack_q   <= '0;
      m_rdata_q <= '0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
`ifdef XBAR_TIMEOUT_EN
      cnt_q     <= '0;
      m_err_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_ack_q   <= m_ack_d;
      m_rdata_q <= m_rdata_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
`ifdef XBAR_TIMEOUT_EN
      cnt_q     <= cnt_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

  assign bus.m_ack   = m_ack_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.s_req   = s_req_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
`ifdef XBAR_TIMEOUT_EN
  assign bus.m_err   = m_err_q;
`else
  assign bus.m_err   = '0;
`endif

endmodule
